pn_checker: RTL and testbench
=============================

# pn_checker

Receive-side counterpart of the PN sequence generator. It takes a serial bit stream produced by an LFSR with a selectable characteristic polynomial and self-synchronises a local LFSR to it. Once locked, it predicts every following bit, counts bit errors, and reports lock status. It sits between the debounced/sampled input path and the BCD/seven-segment display path, so error counts can be shown on the board.

## Interface
- `WIDTH`, 13, maximum LFSR degree; also the width of `char_poly`
- `WIN`, 64, number of checked bits per loss-of-lock window
- `LOSS_THR`, 8, number of errors within one window that forces resynchronisation
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `bit_in`  in  1  received PN bit
- `bit_valid`  in  1  `bit_in` is accepted on this rising edge
- `num`  in  4  LFSR degree; legal values 2..13; values outside that range hold the block in SEED
- `char_poly`  in  WIDTH  tap mask; bit k set means state bit k feeds the XOR
- `locked`  out  1  local LFSR is synchronised and checking
- `err_pulse`  out  1  one-cycle pulse for each mismatched bit
- `err_count`  out  16  total errors since reset or resync; saturates at 16'hFFFF
- `bit_count`  out  16  total bits checked since reset or resync; saturates at 16'hFFFF

## Operation
- State register `lfsr[WIDTH-1:0]`. Only the low `num` bits are used; upper bits are forced to 0 on every update.
- Prediction: `pred = ^(lfsr & char_poly & degree_mask)`. The shift is `lfsr <= {lfsr[WIDTH-2:0], x}`, where `x` is the incoming bit.
- FSM states: SEED, CHECK.
- **SEED:**
  - Each `bit_valid` shifts `bit_in` into `lfsr` and increments `fill_cnt`.
  - When `fill_cnt` reaches `num`, go to CHECK and clear `err_count`, `bit_count` and the window counters.
  - No errors are counted in SEED.
- **CHECK:**
  - Each `bit_valid` compares `bit_in` against `pred`.
  - On mismatch, `err_pulse` is 1 in the following cycle and `err_count` increments.
  - `bit_count` increments on every valid bit.
  - `lfsr` shifts in `pred`, not `bit_in` (free-run), so a single bit error counts exactly once.
- **Window:**
  - `win_bits` counts valid bits in CHECK and `win_errs` counts errors.
  - The bit that completes the window (`win_bits == WIN-1` before increment) is included in that window. Both counters then clear.
- **Configuration change:** any change of `num` or `char_poly` (compared against registered copies) forces SEED on the next edge with `fill_cnt = 0`. The change takes priority over a same-cycle `bit_valid`, and that bit is discarded.
- **Reset:** `rst` overrides everything, including during SEED or CHECK.
- Cycles with `bit_valid = 0` change no state.

## Timing
- Reset values: state SEED, `lfsr` 0, `fill_cnt` 0, `locked` 0, `err_pulse` 0, `err_count` 0, `bit_count` 0, window counters 0.
- All outputs are registered.
- `locked` rises one cycle after the edge that accepts the `num`-th seed bit.
- `err_pulse`, `err_count` and `bit_count` update one cycle after the accepting edge.
- Loss of lock: `locked` falls on the edge after the window-closing bit.
- A window can close together with an error on that same bit. That error counts toward `LOSS_THR` and is reflected in `err_count` before the reset to SEED.
- Throughput: one bit per clock. `bit_valid` may be asserted continuously.

## Configuration
- `PN_CHECK_LOSS_EN`
  - **Defined:** window monitor active. In CHECK, `win_errs >= LOSS_THR` at the window close causes SEED. `err_count` and `bit_count` hold their values until the next lock clears them.
  - **Undefined:** no window logic. Once locked, the block stays in CHECK until `rst` or a configuration change. `WIN` and `LOSS_THR` are ignored.

## Structure
- Package `pn_pkg`:
  - FSM state enum (SEED, CHECK)
  - `PN_MAX_DEG` = 13 and `PN_MIN_DEG` = 2
  - 16-bit counter saturation constant
  - function returning the degree mask for a given `num`
- Sub-module `pn_lock_monitor`: window bit/error counters and the threshold compare. Its output is a one-cycle `lose_lock`. It is instantiated only under `PN_CHECK_LOSS_EN`.

## Test plan
- **Clean lock:** `num` = 4, `char_poly` = 13'h000C, seed 4'b0001 followed by 100 correct continuous bits. Expected: `locked` = 1 one cycle after the 4th bit, `err_count` 0, `bit_count` 100, `err_pulse` never asserted.
- **Single error:** same setup with bit 50 of the check stream inverted. Expected: exactly one `err_pulse`, `err_count` 1, `bit_count` 100, lock held.
- **Loss of lock** (`PN_CHECK_LOSS_EN`, `WIN` 64, `LOSS_THR` 8): invert 8 bits inside the first window. Expected: `locked` falls the cycle after the 64th checked bit, 4 reseed bits relock, counters read 0. Build without the macro: `locked` stays 1 and `err_count` = 8.
- **Configuration change mid-CHECK:** switch `num` 4→5 with `char_poly` = 13'h0014 on a `bit_valid` cycle. Expected: that bit is discarded, `locked` falls next cycle, and 5 seed bits relock.
- **Reset and gaps:** `rst` pulse during CHECK returns all outputs to 0. Bits with `bit_valid` gaps of 1–7 idle cycles produce the same counts as a continuous stream.
- **Illegal degree and saturation:** `num` = 1 or 14 keeps `locked` 0. 70000 clean bits leave `bit_count` at 16'hFFFF.

Source files
------------

// File: rtl/pn_checker_pkg.sv
// Shared types, limits and helpers for the PN sequence checker.
package pn_pkg;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } pn_state_e;

  localparam int unsigned PN_MAX_DEG = 13;
  localparam int unsigned PN_MIN_DEG = 2;
  localparam logic [15:0] PN_CNT_SAT = 16'hFFFF;

  // Low `num` bits set; zero for num == 0.
  function automatic logic [PN_MAX_DEG-1:0] degree_mask(input logic [3:0] num);
    logic [PN_MAX_DEG-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < PN_MAX_DEG; i++) begin
      if (i < 32'(num)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pn_checker_if.sv
// Bit-stream input, configuration and status bundle of pn_checker.
interface pn_checker_if
  import pn_pkg::*;
#(
  parameter int unsigned WIDTH = PN_MAX_DEG
);
  logic             bit_in;
  logic             bit_valid;
  logic [3:0]       num;
  logic [WIDTH-1:0] char_poly;
  logic             locked;
  logic             err_pulse;
  logic [15:0]      err_count;
  logic [15:0]      bit_count;

  modport master (
    output bit_in, bit_valid, num, char_poly,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, num, char_poly,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/pn_checker_lock_monitor.sv
// Loss-of-lock window monitor: counts checked bits and errors per WIN-bit
// window and pulses lose_lock when a window closes with >= LOSS_THR errors.
module pn_lock_monitor #(
  parameter int unsigned WIN      = 64,
  parameter int unsigned LOSS_THR = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_err,
  output logic lose_lock
);
  localparam int unsigned CW = $clog2(WIN + 1);

  logic [CW-1:0] win_bits;
  logic [CW-1:0] win_errs;
  logic [CW-1:0] errs_next;

  // The window-closing bit's own error is included in the threshold compare.
  always_comb begin
    errs_next = win_errs + CW'(bit_err);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_bits  <= '0;
      win_errs  <= '0;
      lose_lock <= 1'b0;
    end else begin
      lose_lock <= 1'b0;
      if (bit_valid) begin
        if (32'(win_bits) == WIN - 1) begin
          lose_lock <= (32'(errs_next) >= LOSS_THR);
          win_bits  <= '0;
          win_errs  <= '0;
        end else begin
          win_bits <= win_bits + CW'(1);
          win_errs <= errs_next;
        end
      end
    end
  end
endmodule

// File: rtl/pn_checker.sv
// Self-synchronising PN sequence checker with error/bit counters.
// Define PN_CHECK_LOSS_EN to enable loss-of-lock resynchronisation.
module pn_checker
  import pn_pkg::*;
#(
  parameter int unsigned WIDTH    = PN_MAX_DEG,
  parameter int unsigned WIN      = 64,
  parameter int unsigned LOSS_THR = 8
) (
  input logic       clk,
  input logic       rst,
  pn_checker_if.slave pn
);
  pn_state_e        state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] poly_q;
  logic [3:0]       num_q;
  logic [3:0]       fill_cnt;
  logic             locked_q;
  logic             err_pulse_q;
  logic [15:0]      err_cnt;
  logic [15:0]      bit_cnt;

  logic pred, mism, cfg_change, num_legal;
  logic seed_valid, lock_start, chk_valid, lose_lock;

  if (WIN < 1 || LOSS_THR < 1) begin : g_bad_params
    $error("pn_checker: WIN and LOSS_THR must be at least 1");
  end

  always_comb begin
    mask       = WIDTH'(degree_mask(pn.num));
    pred       = ^(lfsr & pn.char_poly & mask);
    mism       = pn.bit_in ^ pred;
    cfg_change = (pn.num != num_q) || (pn.char_poly != poly_q);
    num_legal  = (32'(pn.num) >= PN_MIN_DEG) && (32'(pn.num) <= PN_MAX_DEG) &&
                 (32'(pn.num) <= WIDTH);
    seed_valid = (state == SEED) && pn.bit_valid && num_legal && !cfg_change;
    lock_start = seed_valid && (fill_cnt == pn.num - 4'd1);
    chk_valid  = (state == CHECK) && pn.bit_valid && !cfg_change && !lose_lock;
  end

`ifdef PN_CHECK_LOSS_EN
  pn_lock_monitor #(
    .WIN      (WIN),
    .LOSS_THR (LOSS_THR)
  ) u_lock_mon (
    .clk       (clk),
    .rst       (rst),
    .clear     (lock_start),
    .bit_valid (chk_valid),
    .bit_err   (mism),
    .lose_lock (lose_lock)
  );
`else
  assign lose_lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEED;
      lfsr        <= '0;
      fill_cnt    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt     <= '0;
      bit_cnt     <= '0;
      num_q       <= pn.num;
      poly_q      <= pn.char_poly;
    end else begin
      err_pulse_q <= 1'b0;
      num_q       <= pn.num;
      poly_q      <= pn.char_poly;
      // Config change and loss of lock both drop the bit presented this cycle.
      if (cfg_change || lose_lock) begin
        state    <= SEED;
        fill_cnt <= '0;
        locked_q <= 1'b0;
      end else if (seed_valid) begin
        lfsr <= {lfsr[WIDTH-2:0], pn.bit_in} & mask;
        if (lock_start) begin
          state    <= CHECK;
          locked_q <= 1'b1;
          fill_cnt <= '0;
          err_cnt  <= '0;
          bit_cnt  <= '0;
        end else begin
          fill_cnt <= fill_cnt + 4'd1;
        end
      end else if (chk_valid) begin
        // Free-run on the prediction so one corrupted bit is counted once.
        lfsr        <= {lfsr[WIDTH-2:0], pred} & mask;
        err_pulse_q <= mism;
        if (mism && err_cnt != PN_CNT_SAT) err_cnt <= err_cnt + 16'd1;
        if (bit_cnt != PN_CNT_SAT) bit_cnt <= bit_cnt + 16'd1;
      end
    end
  end

  assign pn.locked    = locked_q;
  assign pn.err_pulse = err_pulse_q;
  assign pn.err_count = err_cnt;
  assign pn.bit_count = bit_cnt;
endmodule

// File: tb/tb_pn_checker.sv
// Directed bench for pn_checker: behavioural model checked every cycle plus
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_pn_checker;
  import pn_pkg::*;

  localparam int unsigned W     = 13;
  localparam int unsigned WIN_P = 64;
  localparam int unsigned THR_P = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pn_checker_if #(.WIDTH(W)) pn_bus ();

  pn_checker #(
    .WIDTH    (W),
    .WIN      (WIN_P),
    .LOSS_THR (THR_P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pn  (pn_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  bit run_cmp  = 1'b0;

  // Model: expected outputs from the behavioural rules, history newest-first.
  bit        m_locked, m_pulse, m_pend;
  int        m_errs, m_bits, m_fill, m_wbits, m_werrs, m_num;
  bit [12:0] m_poly;
  bit        hist[$];

  bit [12:0] tx_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pred();
    bit p = 1'b0;
    for (int k = 0; k < m_num && k < hist.size(); k++)
      if (m_poly[k]) p ^= hist[k];
    return p;
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit b, input int n, input bit [12:0] poly);
    bit p, e;
    m_pulse = 1'b0;
    if (r) begin
      m_locked = 0; m_errs = 0; m_bits = 0; m_fill = 0; m_wbits = 0; m_werrs = 0;
      m_pend = 0; hist.delete(); m_num = n; m_poly = poly;
      return;
    end
    if (n != m_num || poly != m_poly) begin
      m_num = n; m_poly = poly; m_locked = 0; m_fill = 0; m_pend = 0; hist.delete();
      return;
    end
    if (m_pend) begin
      m_pend = 0; m_locked = 0; m_fill = 0; hist.delete();
      return;
    end
    if (!v) return;
    if (!m_locked) begin
      if (n < 2 || n > 13) return;
      hist.push_front(b);
      m_fill++;
      if (m_fill == n) begin
        m_locked = 1; m_fill = 0; m_errs = 0; m_bits = 0; m_wbits = 0; m_werrs = 0;
      end
    end else begin
      p = model_pred();
      e = (b != p);
      m_pulse = e;
      if (e && m_errs < 65535) m_errs++;
      if (m_bits < 65535) m_bits++;
      hist.push_front(p);
`ifdef PN_CHECK_LOSS_EN
      m_wbits++;
      m_werrs += int'(e);
      if (m_wbits == WIN_P) begin
        m_pend  = (m_werrs >= THR_P);
        m_wbits = 0;
        m_werrs = 0;
      end
`endif
    end
    while (hist.size() > 16) void'(hist.pop_back());
  endtask

  task automatic step(input bit v, input bit b);
    @(negedge clk);
    pn_bus.bit_valid = v;
    pn_bus.bit_in    = b;
    model_edge(rst, v, b, int'(pn_bus.num), pn_bus.char_poly);
    @(posedge clk);
    #1;
  endtask

  task automatic tx_send(input bit flip, output bit sent);
    bit [12:0] mk;
    bit        b;
    mk   = 13'((32'd1 << pn_bus.num) - 1);
    b    = ^(tx_s & pn_bus.char_poly & mk);
    tx_s = ((tx_s << 1) | 13'(b)) & mk;
    sent = b;
    step(1'b1, b ^ flip);
  endtask

  task automatic seed(input bit [12:0] s);
    tx_s = s;
    for (int i = int'(pn_bus.num) - 1; i >= 0; i--) step(1'b1, s[i]);
  endtask

  always @(posedge clk) begin
    #1;
    if (run_cmp) begin
      chk("locked",    32'(pn_bus.locked),    32'(m_locked));
      chk("err_pulse", 32'(pn_bus.err_pulse), 32'(m_pulse));
      chk("err_count", 32'(pn_bus.err_count), 32'(m_errs));
      chk("bit_count", 32'(pn_bus.bit_count), 32'(m_bits));
      if (pn_bus.err_pulse === 1'b1) n_pulse++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [7:0] first8;
    bit       sb;
    rst = 1'b1;
    pn_bus.bit_valid = 1'b0;
    pn_bus.bit_in    = 1'b0;
    pn_bus.num       = 4'd4;
    pn_bus.char_poly = 13'h000C;
    step(0, 0);
    step(0, 0);
    run_cmp = 1'b1;
    chk("rst_locked", 32'(pn_bus.locked), 0);
    chk("rst_err",    32'(pn_bus.err_count), 0);
    chk("rst_bits",   32'(pn_bus.bit_count), 0);
    chk("rst_pulse",  32'(pn_bus.err_pulse), 0);
    rst = 1'b0;
    step(0, 0);

    // Clean lock
    n_pulse = 0;
    tx_s = 13'h1;
    step(1, 0); step(1, 0); step(1, 0);
    chk("pre_lock", 32'(pn_bus.locked), 0);
    step(1, 1);
    chk("lock_rise", 32'(pn_bus.locked), 1);
    for (int i = 0; i < 100; i++) begin
      tx_send(1'b0, sb);
      if (i < 8) first8[7-i] = sb;
    end
    chk("pn_first8", 32'(first8), 32'h35);
    chk("clean_err",   32'(pn_bus.err_count), 0);
    chk("clean_bits",  32'(pn_bus.bit_count), 100);
    chk("clean_pulse", 32'(n_pulse), 0);

    // Single error at bit 50
    rst = 1'b1; step(0, 0); rst = 1'b0; step(0, 0);
    n_pulse = 0;
    seed(13'h1);
    for (int i = 0; i < 100; i++) tx_send(i == 49, sb);
    chk("single_err",    32'(pn_bus.err_count), 1);
    chk("single_bits",   32'(pn_bus.bit_count), 100);
    chk("single_pulse",  32'(n_pulse), 1);
    chk("single_locked", 32'(pn_bus.locked), 1);

    // Eight errors in the first window
    rst = 1'b1; step(0, 0); rst = 1'b0; step(0, 0);
    seed(13'h1);
    for (int i = 0; i < 64; i++) tx_send((i % 6 == 3) && (i < 48), sb);
    chk("win_err8",   32'(pn_bus.err_count), 8);
    chk("win_locked", 32'(pn_bus.locked), 1);
    tx_send(1'b0, sb);
`ifdef PN_CHECK_LOSS_EN
    chk("loss_fall", 32'(pn_bus.locked), 0);
`else
    chk("loss_hold", 32'(pn_bus.locked), 1);
`endif
    for (int i = 0; i < 4; i++) tx_send(1'b0, sb);
`ifdef PN_CHECK_LOSS_EN
    chk("relock",      32'(pn_bus.locked), 1);
    chk("relock_err",  32'(pn_bus.err_count), 0);
    chk("relock_bits", 32'(pn_bus.bit_count), 0);
`else
    chk("nolos_err",  32'(pn_bus.err_count), 8);
    chk("nolos_bits", 32'(pn_bus.bit_count), 69);
`endif

    // Configuration change on a valid cycle
    for (int i = 0; i < 10; i++) tx_send(1'b0, sb);
    pn_bus.num = 4'd5;
    pn_bus.char_poly = 13'h0014;
    step(1, 1);
    chk("cfg_fall", 32'(pn_bus.locked), 0);
    seed(13'h1);
    chk("cfg_relock", 32'(pn_bus.locked), 1);
    for (int i = 0; i < 30; i++) tx_send(1'b0, sb);
    chk("cfg_err",  32'(pn_bus.err_count), 0);
    chk("cfg_bits", 32'(pn_bus.bit_count), 30);

    // Reset during CHECK, then a gapped stream
    rst = 1'b1;
    pn_bus.num = 4'd4;
    pn_bus.char_poly = 13'h000C;
    step(1, 1);
    chk("midrst_locked", 32'(pn_bus.locked), 0);
    chk("midrst_err",    32'(pn_bus.err_count), 0);
    chk("midrst_bits",   32'(pn_bus.bit_count), 0);
    rst = 1'b0;
    step(0, 0);
    n_pulse = 0;
    seed(13'h1);
    for (int i = 0; i < 100; i++) begin
      tx_send(i == 49, sb);
      for (int g = 0; g < (i % 7) + 1; g++) step(0, 1);
    end
    chk("gap_err",   32'(pn_bus.err_count), 1);
    chk("gap_bits",  32'(pn_bus.bit_count), 100);
    chk("gap_pulse", 32'(n_pulse), 1);

    // Illegal degrees never lock
    pn_bus.num = 4'd1;
    for (int i = 0; i < 20; i++) step(1, i[0]);
    chk("num1_locked", 32'(pn_bus.locked), 0);
    pn_bus.num = 4'd14;
    for (int i = 0; i < 20; i++) step(1, i[1]);
    chk("num14_locked", 32'(pn_bus.locked), 0);

    // Counter saturation
    pn_bus.num = 4'd4;
    step(0, 0);
    seed(13'h1);
    for (int i = 1; i <= 70000; i++) begin
      tx_send(1'b0, sb);
      if (i == 65534) chk("sat_m1", 32'(pn_bus.bit_count), 32'hFFFE);
      if (i == 65535) chk("sat_at", 32'(pn_bus.bit_count), 32'hFFFF);
    end
    chk("sat_bits", 32'(pn_bus.bit_count), 32'hFFFF);
    chk("sat_err",  32'(pn_bus.err_count), 0);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
